// File: rtl/accumulator_pkg.sv
// ---------------------------------------------------------------------------
// accumulator_pkg
//   Shared definitions for the streaming saturating accumulator:
//   - state_e   : two-state FSM encoding (ACC = accepting beats,
//                 RES = holding a result for the consumer)
//   - sat_max() : largest signed value representable in `width` bits
//   - sat_min() : smallest signed value representable in `width` bits
// ---------------------------------------------------------------------------
package accumulator_pkg;

    typedef enum logic {
        ACC = 1'b0,
        RES = 1'b1
    } state_e;

    // 2^(width-1) - 1, computed in 64 bits so any practical width fits.
    function automatic longint sat_max(input int width);
        return (longint'(1) << (width - 1)) - longint'(1);
    endfunction

    // -2^(width-1)
    function automatic longint sat_min(input int width);
        return -(longint'(1) << (width - 1));
    endfunction

endpackage

// File: rtl/accumulator_saturate.sv
// ---------------------------------------------------------------------------
// saturate
//   Purely combinational clip of a (WIDTH+1)-bit signed value into a
//   WIDTH-bit signed result.
//   UPPER is an exclusive bound (the result never exceeds UPPER-1) and
//   LOWER is an inclusive bound, so UPPER = 2^(WIDTH-1) and
//   LOWER = -2^(WIDTH-1) give the full two's complement range.
//
//   Ports:
//     val  in   WIDTH+1  signed value to clip
//     out  out  WIDTH    clipped signed value
// ---------------------------------------------------------------------------
module saturate #(
    parameter int     WIDTH = 16,
    parameter longint UPPER = 64'sd32768,
    parameter longint LOWER = -64'sd32768
) (
    input  logic signed [WIDTH:0]   val,
    output logic signed [WIDTH-1:0] out
);

    // Bounds brought to the width of val so comparisons stay signed and
    // width-matched.
    localparam logic signed [WIDTH:0] HI = (WIDTH + 1)'(UPPER - 64'sd1);
    localparam logic signed [WIDTH:0] LO = (WIDTH + 1)'(LOWER);

    always_comb begin
        if (val > HI) begin
            out = HI[WIDTH-1:0];
        end else if (val < LO) begin
            out = LO[WIDTH-1:0];
        end else begin
            out = val[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/accumulator.sv
// ---------------------------------------------------------------------------
// accumulator
//   Streaming saturating accumulator. Signed samples arrive on a
//   valid/ready stream; each accepted beat is added to a running sum that
//   is saturated at every step. The beat flagged arg_last closes the packet:
//   its saturated sum is registered as the result, together with a sticky
//   flag telling whether any step of the packet clipped.
//
//   Ports:
//     clock      in   1      system clock, rising edge
//     reset      in   1      synchronous, active-high reset
//     arg_valid  in   1      input sample valid
//     arg_ready  out  1      block accepts a sample this cycle
//     arg_data   in   WIDTH  signed input sample
//     arg_last   in   1      final beat of the packet
//     res_valid  out  1      result valid
//     res_ready  in   1      downstream accepts the result
//     res_data   out  WIDTH  signed saturated packet sum
//     res_sat    out  1      some step of the packet saturated
//
//   While a result is pending the block stops accepting input; the cycle
//   after the result handshake it is ready again, so every packet costs at
//   least one bubble cycle.
// ---------------------------------------------------------------------------
module accumulator
    import accumulator_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             arg_valid,
    output logic             arg_ready,
    input  logic [WIDTH-1:0] arg_data,
    input  logic             arg_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_sat
);

    localparam logic signed [WIDTH:0] SAT_MAX_W = (WIDTH + 1)'(sat_max(WIDTH));
    localparam logic signed [WIDTH:0] SAT_MIN_W = (WIDTH + 1)'(sat_min(WIDTH));

    state_e                  state_q;
    logic signed [WIDTH-1:0] acc_q;
    logic                    flag_q;
    logic                    res_valid_q;
    logic        [WIDTH-1:0] res_data_q;
    logic                    res_sat_q;

    logic signed [WIDTH:0]   sum;
    logic signed [WIDTH-1:0] sat_sum;
    logic                    clip;
    logic                    beat_fire;

    // One extra bit of headroom: the sum of two WIDTH-bit signed values
    // always fits in WIDTH+1 bits.
    assign sum = {acc_q[WIDTH-1], acc_q} + {arg_data[WIDTH-1], arg_data};

    saturate #(
        .WIDTH (WIDTH),
        .UPPER (longint'(1) << (WIDTH - 1)),
        .LOWER (-(longint'(1) << (WIDTH - 1)))
    ) u_saturate (
        .val (sum),
        .out (sat_sum)
    );

    // Landing exactly on the minimum is representable, so it is not a clip.
    assign clip      = (sum > SAT_MAX_W) || (sum < SAT_MIN_W);

    // Ready is decoded from state alone, keeping it free of any
    // combinational path from res_ready or arg_valid.
    assign arg_ready = (state_q == ACC);
    assign beat_fire = arg_valid && arg_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ACC;
            acc_q       <= '0;
            flag_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_sat_q   <= 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (beat_fire) begin
                        if (arg_last) begin
                            // Close the packet and start the next one from 0.
                            res_data_q  <= sat_sum;
                            res_sat_q   <= flag_q | clip;
                            res_valid_q <= 1'b1;
                            acc_q       <= '0;
                            flag_q      <= 1'b0;
                            state_q     <= RES;
                        end else begin
                            acc_q  <= sat_sum;
                            flag_q <= flag_q | clip;
                        end
                    end
                end
                RES: begin
                    // res_data/res_sat are left untouched so they stay
                    // stable under backpressure and after the handshake.
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= ACC;
                    end
                end
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_sat   = res_sat_q;

endmodule

// File: tb/tb_accumulator.sv
// ---------------------------------------------------------------------------
// tb_accumulator
//   Directed packets with literal expected results, then a randomized
//   stream of packets with random valid gaps and random backpressure. A
//   negedge monitor keeps a packet-level reference model and compares the
//   DUT outputs against it every cycle.
// ---------------------------------------------------------------------------
module tb_accumulator;

    localparam int WIDTH = 16;
    localparam int SMAX  = 32767;
    localparam int SMIN  = -32768;
    localparam int NPKT  = 60;

    logic             clock = 1'b0;
    logic             reset;
    logic             arg_valid;
    logic             arg_ready;
    logic [WIDTH-1:0] arg_data;
    logic             arg_last;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_sat;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    accumulator #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .arg_valid (arg_valid),
        .arg_ready (arg_ready),
        .arg_data  (arg_data),
        .arg_last  (arg_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_sat   (res_sat)
    );

    task automatic check(input string name, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- reference model (packet level) ----------------
    bit mon_en      = 1'b0;
    bit exp_busy    = 1'b0;
    int m_acc       = 0;
    bit m_flag      = 1'b0;
    int exp_data    = 0;
    bit exp_sat     = 1'b0;
    int results_seen = 0;

    always @(negedge clock) begin : monitor
        bit busy_now;
        int s;
        bit c;
        if (mon_en) begin
            check("mon_res_valid", res_valid, exp_busy);
            check("mon_arg_ready", arg_ready, !exp_busy);
            if (exp_busy) begin
                check("mon_res_data", $signed(res_data), exp_data);
                check("mon_res_sat", res_sat, exp_sat);
            end
            if (reset) begin
                exp_busy = 1'b0;
                m_acc    = 0;
                m_flag   = 1'b0;
            end else begin
                busy_now = exp_busy;
                if (busy_now && res_ready) begin
                    exp_busy = 1'b0;
                    results_seen++;
                end
                if (!busy_now && arg_valid) begin
                    s = m_acc + int'($signed(arg_data));
                    c = 1'b0;
                    if (s > SMAX) begin s = SMAX; c = 1'b1; end
                    if (s < SMIN) begin s = SMIN; c = 1'b1; end
                    if (arg_last) begin
                        exp_data = s;
                        exp_sat  = m_flag | c;
                        exp_busy = 1'b1;
                        m_acc    = 0;
                        m_flag   = 1'b0;
                    end else begin
                        m_acc  = s;
                        m_flag = m_flag | c;
                    end
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one beat and hold it until it is accepted.
    task automatic send_beat(input int d, input bit last);
        bit ok;
        int n;
        n = 0;
        arg_valid = 1'b1;
        arg_data  = 16'(d);
        arg_last  = last;
        do begin
            ok = arg_ready;
            tick();
            n++;
        end while (!ok && n < 50);
        if (!ok) check("send_timeout", 0, 1);
        arg_valid = 1'b0;
        arg_last  = 1'b0;
    endtask

    task automatic get_result(input string name, input int exp_d, input bit exp_s);
        int n;
        n = 0;
        res_ready = 1'b1;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        $display("result %s: data=%0d sat=%0d", name, $signed(res_data), res_sat);
        check({name, "_valid"}, res_valid, 1);
        check({name, "_data"}, $signed(res_data), exp_d);
        check({name, "_sat"}, res_sat, exp_s);
        tick();
        res_ready = 1'b0;
    endtask

    function automatic int rand_sample();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 65535)) - 32768;
            1:       return 32000 + int'($urandom_range(0, 767));
            2:       return -32768 + int'($urandom_range(0, 767));
            default: return int'($urandom_range(0, 200)) - 100;
        endcase
    endfunction

    int  pkts_sent;
    int  pkts_started;
    int  remaining;
    int  base_results;
    int  cyc;
    bit  took;

    initial begin
        reset     = 1'b1;
        arg_valid = 1'b0;
        arg_data  = '0;
        arg_last  = 1'b0;
        res_ready = 1'b0;
        tick();
        mon_en = 1'b1;
        tick();
        reset = 1'b0;
        check("reset_res_valid", res_valid, 0);
        check("reset_arg_ready", arg_ready, 1);
        check("reset_res_data", res_data, 0);
        check("reset_res_sat", res_sat, 0);

        // Basic packet with latency and re-ready checks.
        res_ready = 1'b1;
        send_beat(100, 0);
        send_beat(200, 0);
        send_beat(-50, 1);
        check("t1_latency", res_valid, 1);
        get_result("t1", 250, 1'b0);
        check("t1_arg_ready_after", arg_ready, 1);

        // Saturation boundaries.
        send_beat(30000, 0);  send_beat(30000, 1); get_result("pos_sat", 32767, 1'b1);
        send_beat(-32768, 0); send_beat(-1, 1);    get_result("neg_sat", -32768, 1'b1);
        send_beat(-32767, 0); send_beat(-1, 1);    get_result("neg_edge", -32768, 1'b0);
        send_beat(32767, 0);  send_beat(1, 0); send_beat(-10, 1);
        get_result("per_step", 32757, 1'b1);
        send_beat(5, 1);                           get_result("cleared", 5, 1'b0);

        // Backpressure: result held, next beat held upstream.
        res_ready = 1'b0;
        send_beat(7, 1);
        arg_valid = 1'b1;
        arg_data  = 16'(3);
        arg_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", res_valid, 1);
            check("bp_data", $signed(res_data), 7);
            check("bp_arg_ready", arg_ready, 0);
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("bp_ready_back", arg_ready, 1);
        check("bp_valid_drop", res_valid, 0);
        tick();
        arg_valid = 1'b0;
        arg_last  = 1'b0;
        check("bp_beat3_taken", res_valid, 1);
        get_result("bp_beat3", 3, 1'b0);

        // Reset mid-packet discards the partial sum.
        send_beat(1000, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        send_beat(5, 1);
        get_result("rst_mid", 5, 1'b0);

        // Reset with a pending result, concurrent with a handshake attempt.
        send_beat(9, 1);
        check("rst_res_pending", res_valid, 1);
        reset     = 1'b1;
        res_ready = 1'b1;
        tick();
        reset     = 1'b0;
        res_ready = 1'b0;
        check("rst_res_dropped", res_valid, 0);
        check("rst_res_arg_ready", arg_ready, 1);

        // Randomized stream.
        pkts_sent    = 0;
        pkts_started = 0;
        remaining    = 0;
        cyc          = 0;
        base_results = results_seen;
        while (pkts_sent < NPKT && cyc < 20000) begin
            took      = arg_valid && arg_ready;
            res_ready = ($urandom_range(0, 3) != 0);
            tick();
            cyc++;
            if (took && arg_last) pkts_sent++;
            if (!arg_valid || took) begin
                if ((remaining > 0 || pkts_started < NPKT) && $urandom_range(0, 3) != 0) begin
                    if (remaining == 0) begin
                        remaining = $urandom_range(1, 16);
                        pkts_started++;
                    end
                    arg_data  = 16'(rand_sample());
                    arg_last  = (remaining == 1);
                    remaining--;
                    arg_valid = 1'b1;
                end else begin
                    arg_valid = 1'b0;
                    arg_last  = 1'b0;
                end
            end
        end
        arg_valid = 1'b0;
        arg_last  = 1'b0;
        check("rand_progress", pkts_sent, NPKT);
        res_ready = 1'b1;
        cyc = 0;
        while (results_seen - base_results < NPKT && cyc < 100) begin
            tick();
            cyc++;
        end
        tick();
        $display("random phase: %0d packets sent, %0d results", pkts_sent, results_seen - base_results);
        check("rand_results", results_seen - base_results, NPKT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
